// File: rtl/baud_pkg.sv
// Shared definitions for the baud-rate generator: rate table, divisor helper,
// select validity check and controller state encoding.
package baud_pkg;

  localparam int NUM_RATES = 10;
  localparam int SEL_W     = 4;

  // Indexed by rate code; entry 0 must stay the slowest rate (it sizes the counters).
  localparam int unsigned RATE_TABLE [NUM_RATES] = '{
    1200, 2400, 4800, 9600, 14400, 19200, 28800, 38400, 57600, 115200
  };

  typedef enum logic [1:0] {IDLE, RUN, STALL} baud_state_t;

  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned rate,
                                           input int unsigned ovs);
    return clk_hz / rate / ovs;
  endfunction

  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return int'(sel) < NUM_RATES;
  endfunction

endpackage

// File: rtl/baud_tick_counter.sv
// Modulo-(last+1) up counter with synchronous clear, load and a terminal-count
// flag that is high on the enabled cycle in which the counter wraps.
module baud_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = en && (count == last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/baud_gen_param.sv
// Baud-rate generator: 50% baud clock, bit tick and (with BAUD_OVS_EN defined)
// an oversampling tick; without BAUD_OVS_EN a half-bit counter drives the same outputs.
module baud_gen_param
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ = 14_745_600,
  parameter int unsigned OVS    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Sync,
  input  logic [SEL_W-1:0] Baud_select,
  output logic             Clock_out,
  output logic             Bit_tick,
  output logic             Ovs_tick,
  output logic [SEL_W-1:0] Active_sel,
  output logic             Sel_err
);

  // The phase counter counts sub-periods per bit: OVS ticks, or two half-bits.
`ifdef BAUD_OVS_EN
  localparam int unsigned PH = OVS;
`else
  localparam int unsigned PH = 2;
`endif
  localparam int unsigned MAX_DIV = baud_div(CLK_HZ, RATE_TABLE[0], 1);
  localparam int CNT_W = $clog2(MAX_DIV);
  localparam int PH_W  = $clog2(PH);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(PH / 2 - 1);

  if (OVS < 2 || (OVS % 2) != 0) begin : g_bad_ovs
    $error("baud_gen_param: OVS must be even and at least 2");
  end

  for (genvar i = 0; i < NUM_RATES; i++) begin : g_check
    if ((CLK_HZ % RATE_TABLE[i]) != 0 || ((CLK_HZ / RATE_TABLE[i]) % PH) != 0) begin : g_bad
      $error("baud_gen_param: CLK_HZ does not divide evenly for rate code %0d", i);
    end
  end

  logic [CNT_W-1:0] inner_last_tbl [2**SEL_W];

  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_tbl
    if (i < NUM_RATES) begin : g_rate
      assign inner_last_tbl[i] = CNT_W'(baud_div(CLK_HZ, RATE_TABLE[i], PH) - 1);
    end else begin : g_none
      assign inner_last_tbl[i] = '0;
    end
  end

  baud_state_t      state;
  logic [SEL_W-1:0] active_sel;
  logic             sel_err;
  logic             clock_out;
  logic             bit_tick;
  logic             sel_ok;
  logic             restart;
  logic             run;
  logic             sample;
  logic             inner_tc;
  logic             bit_term;
  logic             half_term;
  logic [CNT_W-1:0] inner_last;
  logic [CNT_W-1:0] inner_cnt_unused;
  logic [PH_W-1:0]  phase;

  assign sel_ok     = sel_valid(Baud_select);
  assign restart    = !Enable || (state != RUN) || Sync;
  assign run        = !restart;
  assign inner_last = inner_last_tbl[active_sel];
  assign half_term  = inner_tc && (phase == PH_HALF);
  // The select only moves at a bit boundary while running, so a period is never cut short.
  assign sample     = (state != RUN) || Sync || bit_term;

  baud_tick_counter #(.W(CNT_W)) u_ovs (
    .clk      (Clk),
    .rst      (Reset),
    .clr      (restart),
    .load     (1'b0),
    .en       (run),
    .load_val ('0),
    .last     (inner_last),
    .count    (inner_cnt_unused),
    .tc       (inner_tc)
  );

  baud_tick_counter #(.W(PH_W)) u_phase (
    .clk      (Clk),
    .rst      (Reset),
    .clr      (restart),
    .load     (1'b0),
    .en       (inner_tc),
    .load_val ('0),
    .last     (PH_LAST),
    .count    (phase),
    .tc       (bit_term)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      active_sel <= '0;
      sel_err    <= 1'b0;
      clock_out  <= 1'b0;
      bit_tick   <= 1'b0;
    end else begin
      bit_tick <= 1'b0;
      if (sample) begin
        active_sel <= Baud_select;
        sel_err    <= !sel_ok;
      end
      if (!Enable) begin
        state     <= IDLE;
        clock_out <= 1'b0;
      end else if (restart) begin
        state     <= sel_ok ? RUN : STALL;
        clock_out <= 1'b0;
      end else if (bit_term) begin
        bit_tick  <= 1'b1;
        clock_out <= 1'b0;
        if (!sel_ok) state <= STALL;
      end else if (half_term) begin
        clock_out <= 1'b1;
      end
    end
  end

`ifdef BAUD_OVS_EN
  logic ovs_tick;

  always_ff @(posedge Clk) begin
    if (Reset) ovs_tick <= 1'b0;
    else       ovs_tick <= inner_tc;
  end

  assign Ovs_tick = ovs_tick;
`else
  assign Ovs_tick = 1'b0;
`endif

  assign Clock_out  = clock_out;
  assign Bit_tick   = bit_tick;
  assign Active_sel = active_sel;
  assign Sel_err    = sel_err;

endmodule

// File: tb/tb_baud_gen_param.sv
// Bench for baud_gen_param: directed vector table, a full slow-rate period,
// and randomized stimulus against an elapsed-time reference model.
module tb_baud_gen_param;

  localparam int unsigned CLK_HZ = 14_745_600;
  localparam int unsigned OVS    = 16;
`ifdef BAUD_OVS_EN
  localparam bit OVS_EN = 1'b1;
`else
  localparam bit OVS_EN = 1'b0;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STALL = 2;

  logic       clk = 1'b0;
  logic       rst, en, sync;
  logic [3:0] sel;
  logic       clk_o, bit_o, ovs_o, serr_o;
  logic [3:0] asel_o;

  int total = 0;
  int bad   = 0;

  int rates [10] = '{1200, 2400, 4800, 9600, 14400, 19200, 28800, 38400, 57600, 115200};

  typedef struct {
    logic       rst, en, sync;
    logic [3:0] sel;
    int         n;
    logic       c, b, o, e;
    logic [3:0] a;
  } vec_t;

  vec_t vecs[$];

  baud_gen_param #(.CLK_HZ(CLK_HZ), .OVS(OVS)) dut (
    .Clk         (clk),
    .Reset       (rst),
    .Enable      (en),
    .Sync        (sync),
    .Baud_select (sel),
    .Clock_out   (clk_o),
    .Bit_tick    (bit_o),
    .Ovs_tick    (ovs_o),
    .Active_sel  (asel_o),
    .Sel_err     (serr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic r, e, s, input logic [3:0] sl, input int n,
                         input logic c, b, o, er, input logic [3:0] a);
    vec_t v;
    v.rst = r; v.en = e; v.sync = s; v.sel = sl; v.n = n;
    v.c = c; v.b = b; v.o = o; v.e = er; v.a = a;
    vecs.push_back(v);
  endtask

  function automatic int outs();
    return int'({clk_o, bit_o, ovs_o, serr_o, asel_o});
  endfunction

  // Reference model: elapsed cycles since period start, outputs from plain arithmetic.
  int         m_st, m_t;
  logic       m_clk, m_bit, m_ovs, m_serr;
  logic [3:0] m_asel;

  task automatic model_step(input logic r, e, s, input logic [3:0] sl);
    int bd;
    m_bit = 1'b0;
    m_ovs = 1'b0;
    if (r) begin
      m_st = M_IDLE; m_t = 0; m_clk = 1'b0; m_asel = 4'd0; m_serr = 1'b0;
    end else if (!e) begin
      if (m_st != M_RUN || s) begin m_asel = sl; m_serr = (sl >= 4'd10); end
      m_st = M_IDLE; m_t = 0; m_clk = 1'b0;
    end else if (m_st != M_RUN || s) begin
      m_asel = sl; m_serr = (sl >= 4'd10);
      m_st = (sl < 4'd10) ? M_RUN : M_STALL;
      m_t = 0; m_clk = 1'b0;
    end else begin
      bd = int'(CLK_HZ) / rates[int'(m_asel)];
      m_t = m_t + 1;
      m_ovs = OVS_EN && ((m_t % (bd / int'(OVS))) == 0);
      m_clk = (m_t >= bd / 2) && (m_t < bd);
      if (m_t == bd) begin
        m_bit = 1'b1; m_t = 0;
        m_asel = sl; m_serr = (sl >= 4'd10);
        if (sl >= 4'd10) m_st = M_STALL;
      end
    end
  endtask

  initial begin
    int hi_cnt, ovs_cnt, bit_cnt, bit_at, r;

    rst = 1'b1; en = 1'b0; sync = 1'b0; sel = 4'd0;

    //       rst en sy sel  n     clk bit ovs err asel
    add_vec(1, 0, 0, 0,  2,    0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 9,  1,    0, 0, 0, 0, 9);
    add_vec(0, 1, 0, 9,  7,    0, 0, 0, 0, 9);
    add_vec(0, 1, 0, 9,  1,    0, 0, 1, 0, 9);
    add_vec(0, 1, 0, 9,  1,    0, 0, 0, 0, 9);
    add_vec(0, 1, 0, 9,  54,   0, 0, 0, 0, 9);
    add_vec(0, 1, 0, 9,  1,    1, 0, 1, 0, 9);
    add_vec(0, 1, 0, 9,  63,   1, 0, 0, 0, 9);
    add_vec(0, 1, 0, 9,  1,    0, 1, 1, 0, 9);
    add_vec(0, 1, 0, 12, 1,    0, 0, 0, 0, 9);
    add_vec(0, 1, 0, 12, 127,  0, 1, 1, 1, 12);
    add_vec(0, 1, 0, 12, 1,    0, 0, 0, 1, 12);
    add_vec(0, 1, 0, 5,  1,    0, 0, 0, 0, 5);
    add_vec(0, 1, 0, 5,  767,  1, 0, 0, 0, 5);
    add_vec(0, 1, 0, 5,  1,    0, 1, 1, 0, 5);
    add_vec(0, 1, 0, 9,  100,  0, 0, 0, 0, 5);
    add_vec(0, 1, 1, 9,  1,    0, 0, 0, 0, 9);
    add_vec(0, 1, 0, 9,  127,  1, 0, 0, 0, 9);
    add_vec(0, 1, 0, 9,  1,    0, 1, 1, 0, 9);
    add_vec(0, 1, 0, 9,  100,  1, 0, 0, 0, 9);
    add_vec(0, 1, 1, 9,  1,    0, 0, 0, 0, 9);
    add_vec(0, 1, 0, 9,  127,  1, 0, 0, 0, 9);
    add_vec(0, 1, 0, 9,  1,    0, 1, 1, 0, 9);
    add_vec(0, 1, 0, 4,  1,    0, 0, 0, 0, 9);
    add_vec(0, 1, 0, 4,  127,  0, 1, 1, 0, 4);
    add_vec(0, 1, 0, 4,  600,  1, 0, 0, 0, 4);
    add_vec(1, 1, 0, 4,  1,    0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 4,  1,    0, 0, 0, 0, 4);
    add_vec(0, 1, 0, 4,  1024, 0, 1, 1, 0, 4);
    add_vec(0, 1, 0, 4,  700,  1, 0, 0, 0, 4);
    add_vec(0, 0, 0, 4,  1,    0, 0, 0, 0, 4);
    add_vec(0, 0, 0, 13, 3,    0, 0, 0, 1, 13);
    add_vec(0, 1, 0, 3,  1,    0, 0, 0, 0, 3);
    add_vec(0, 1, 0, 9,  1535, 1, 0, 0, 0, 3);
    add_vec(0, 1, 0, 9,  1,    0, 1, 1, 0, 9);
    add_vec(0, 1, 0, 9,  128,  0, 1, 1, 0, 9);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; sync = vecs[i].sync; sel = vecs[i].sel;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(),
            int'({vecs[i].c, vecs[i].b, vecs[i].o & OVS_EN, vecs[i].e, vecs[i].a}));
    end

    // One full 1200-baud period from a fresh enable.
    rst = 1'b1; en = 1'b0; sync = 1'b0; sel = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    hi_cnt = 0; ovs_cnt = 0; bit_cnt = 0; bit_at = -1;
    for (int k = 1; k <= 12288; k++) begin
      @(posedge clk); #1;
      if (clk_o) hi_cnt++;
      if (ovs_o) ovs_cnt++;
      if (bit_o) begin bit_cnt++; bit_at = k; end
    end
    check("slow_high_cycles", hi_cnt, 6144);
    check("slow_ovs_ticks", ovs_cnt, OVS_EN ? 16 : 0);
    check("slow_bit_ticks", bit_cnt, 1);
    check("slow_bit_position", bit_at, 12288);

    for (int c = 0; c < 8000; c++) begin
      r = int'($urandom_range(0, 999));
      rst  = (c == 0) || (r < 2);
      en   = ($urandom_range(0, 199) != 0);
      sync = ($urandom_range(0, 149) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 80)      sel = 4'($urandom_range(8, 9));
      else if (r < 92) sel = 4'($urandom_range(6, 7));
      else             sel = 4'($urandom_range(10, 15));
      @(posedge clk);
      model_step(rst, en, sync, sel);
      #1;
      check($sformatf("rand%0d", c), outs(),
            int'({m_clk, m_bit, m_ovs, m_serr, m_asel}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baud_gen_param.md
# baud_gen_param

Parametrised baud-rate generator for the serial blocks: from one system clock it produces a 50%-duty baud clock, a one-cycle bit-rate tick and, optionally, an oversampling tick for UART receivers. It supports ten standard rates, divisors derived from a clock-frequency parameter, glitch-free rate changes at bit boundaries, enable/phase-restart control and detection of invalid rate selects. It sits between the register interface (rate select) and the UART TX/RX shifters.

## Interface
- `CLK_HZ`, 14_745_600: system clock frequency in Hz.
- `OVS`, 16: oversampling factor. Must be even and ≥2.
- `Clk` in 1: system clock.
- `Reset` in 1: one clock; reset is synchronous and active-high.
- `Enable` in 1: run when 1. When 0, counters are cleared and outputs are held low.
- `Sync` in 1: single-cycle phase restart, used by RX on start-bit detection.
- `Baud_select` in 4: rate code. 0..9 = 1200, 2400, 4800, 9600, 14400, 19200, 28800, 38400, 57600, 115200. 10..15 are invalid.
- `Clock_out` out 1: baud clock with 50% duty. Period is bit_div cycles.
- `Bit_tick` out 1: one-cycle pulse, once per bit period.
- `Ovs_tick` out 1: one-cycle pulse, OVS times per bit period.
- `Active_sel` out 4: rate code currently in effect.
- `Sel_err` out 1: high while the latched select is invalid.

## Operation
- Divisors:
  - bit_div = CLK_HZ / rate.
  - ovs_div = bit_div / OVS.
  - Elaboration fails if any rate leaves a nonzero remainder.
  - Defaults give bit_div 12288..128 and ovs_div 768..8.
- Counter width = $clog2(max divisor). All compares are unsigned. Counters wrap to 0 on terminal count, never by overflow.
- States:
  - IDLE: `Enable`=0 or just after reset.
  - RUN.
  - STALL: invalid select latched.
- Transitions:
  - IDLE→RUN when `Enable`=1 and the sampled select is valid.
  - IDLE→STALL when `Enable`=1 and the sampled select is invalid.
  - RUN→STALL when an invalid select is sampled at a bit boundary.
  - STALL→RUN when a valid select is sampled.
  - Any state→IDLE when `Enable`=0.
- `Baud_select` sampling into `Active_sel`:
  - Every cycle in IDLE and STALL.
  - On any cycle with `Sync`=1.
  - On the cycle `Bit_tick`=1.
  - Never mid-bit: a mid-bit change does not disturb the current period.
- In RUN:
  - The ovs counter counts 0..ovs_div-1 and pulses `Ovs_tick` on terminal count.
  - The phase counter counts `Ovs_tick`s 0..OVS-1.
  - `Clock_out` rises on the OVS/2-th tick and falls on the OVS-th tick.
  - `Bit_tick` coincides with the OVS-th tick.
- `Sync`=1 clears both counters and drives `Clock_out` low. The next `Bit_tick` follows exactly bit_div cycles later. `Sync` overrides a coincident terminal count.
- In STALL: `Sel_err`=1, counters held at 0, all ticks and `Clock_out` low.
- Priority: `Reset` > `Enable`=0 > `Sync` > terminal count.

## Timing
- Reset values: `Clock_out`=0, `Bit_tick`=0, `Ovs_tick`=0, `Sel_err`=0, `Active_sel`=0, counters 0, state IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- First `Ovs_tick` comes ovs_div cycles after the first cycle `Enable` is sampled high.
- First `Bit_tick` comes bit_div cycles after that same cycle.
- A new rate latched on a `Bit_tick` cycle governs the very next period.
- `Sel_err` and `Active_sel` update one cycle after sampling.
- `Reset` or `Enable`=0 mid-bit truncates the period immediately: outputs go low the next cycle with no partial tick.

## Configuration
- `BAUD_OVS_EN` defined:
  - ovs counter plus phase counter as described above.
  - `Ovs_tick` is live.
- `BAUD_OVS_EN` undefined:
  - A single counter counts half-bit periods (bit_div/2).
  - `Ovs_tick` is tied 0 and the `OVS` parameter is ignored.
  - `Bit_tick`, `Clock_out`, select and `Sync` behaviour are cycle-identical to the defined case.

## Structure
- Package `baud_pkg`:
  - `NUM_RATES`=10.
  - Rate table (integer array indexed by code).
  - Function `baud_div(clk_hz, rate, ovs)`.
  - Enum `baud_state_t` {IDLE, RUN, STALL}.
- Sub-module `baud_tick_counter`: parametrised modulo-N counter with load, clear and terminal-count pulse. It is instantiated once for the ovs count and once for the phase count.

## Test plan
- Default parameters, select 9, `Enable` rising at T0 → `Ovs_tick` at T0+8, 16, …; `Bit_tick` and `Clock_out` fall at T0+128; `Clock_out` rise at T0+64.
- Select 0 → `Clock_out` period 12288 cycles, high for exactly 6144; 16 `Ovs_tick`s per `Bit_tick`.
- Select changed 3→9 mid-bit → the current period completes at 1536 cycles, and the next period is 128 cycles.
- Select 12 while enabled → `Sel_err`=1 and outputs low; then select 5 → `Sel_err`=0 and first `Bit_tick` 768 cycles later.
- `Sync` pulse 100 cycles into a select-9 period → `Clock_out` low the next cycle; next `Bit_tick` 128 cycles after `Sync`.
- `Reset` mid-period at select 4 → all outputs 0 and `Active_sel`=0 the next cycle; counting restarts from 0 after release.
